// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, RW/opcode constants
// and the byte span of the word array.
package mem_if_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;
  localparam logic [3:0] OP_LDR   = 4'b1101;
  localparam logic [3:0] OP_STR   = 4'b1110;

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  // Byte span of the array, wide enough that 4*depth never wraps.
  function automatic logic [33:0] byte_span(int unsigned depth);
    return 34'(depth) << 2;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, synchronous read, no reset.
// The read register only changes on a read, so it holds the last read word.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Wait-stated memory responder with a 4-phase req/ready handshake, address range
// checking and error reporting.
module data_memory_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        RW,
  input  logic [31:0] AddressBus,
  input  logic [31:0] Dout,
  output logic [31:0] Din,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] Span = byte_span(DEPTH_WORDS);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            rw_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            ready_q;
  logic            err_q;
  logic            din_zero_q;

  logic [31:0]     offset;
  logic            addr_bad;
  logic            access;
  logic [IdxW-1:0] idx;
  logic [31:0]     rdata;

  // Range check uses the full 32-bit offset; truncation to the index happens afterwards.
  assign offset   = addr_q - BASE_ADDR;
  assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                    ({2'b00, offset} >= Span);
  assign idx      = offset[IdxW+1:2];
  assign access   = (state_q == StWait) && (cnt_q == '0);

  mem_array #(
    .Depth (DEPTH_WORDS),
    .AddrW (IdxW)
  ) u_mem (
    .clk_i   (clk),
    .en_i    (access && !addr_bad),
    .we_i    (rw_q == RW_WRITE),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rw_q       <= RW_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      din_zero_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            rw_q    <= RW;
            addr_q  <= AddressBus;
            wdata_q <= Dout;
            cnt_q   <= CntW'(WAIT_STATES);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StDone;
            ready_q <= 1'b1;
            err_q   <= addr_bad;
            // A good write leaves Din alone; a good read exposes the array's read register.
            if (addr_bad) begin
              din_zero_q <= 1'b1;
            end else if (rw_q == RW_READ) begin
              din_zero_q <= 1'b0;
            end
          end
        end
        StDone: begin
          if (!req) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Din   = din_zero_q ? '0 : rdata;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model, plus directed literal cases.
module tb_data_memory_responder;
  import mem_if_pkg::*;

  localparam longint unsigned Depth = 256;
  localparam longint unsigned Base  = 0;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        req [2];
  logic [31:0] din [2];
  logic        rdy [2];
  logic        er  [2];

  int n_cmp;
  int n_bad;

  data_memory_responder #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req[0]),
    .RW         (rw),
    .AddressBus (addr),
    .Dout       (dout),
    .Din        (din[0]),
    .ready      (rdy[0]),
    .err        (er[0])
  );

  data_memory_responder #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (0)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req[1]),
    .RW         (rw),
    .AddressBus (addr),
    .Dout       (dout),
    .Din        (din[1]),
    .ready      (rdy[1]),
    .err        (er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit is_bad(logic [31:0] a);
    longint unsigned off;
    off = longint'(a) - Base;
    return (a[1:0] != 2'b00) || (longint'(a) < Base) || (off >= 4 * Depth);
  endfunction

  function automatic int key_of(int k, logic [31:0] a);
    return k * 65536 + int'((longint'(a) - Base) >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access accepted at edge N completes at edge N+WS+1.
  bit          m_busy [2];
  bit          m_done [2];
  int          m_due  [2];
  int          m_edge;
  logic        m_rw   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_mem  [int];
  logic        exp_ready [2];
  logic        exp_err   [2];
  logic [31:0] exp_din   [2];

  initial begin
    m_edge = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_due[k] = 0;
      exp_ready[k] = 1'b0; exp_err[k] = 1'b0; exp_din[k] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_busy[k] = 0; m_done[k] = 0;
          exp_ready[k] = 1'b0; exp_err[k] = 1'b0; exp_din[k] = '0;
        end
      end else begin
        m_edge++;
        for (int k = 0; k < 2; k++) begin
          if (!m_busy[k]) begin
            if (req[k]) begin
              m_busy[k] = 1;
              m_due[k]  = m_edge + ws_of(k) + 1;
              m_rw[k]   = rw;
              m_addr[k] = addr;
              m_data[k] = dout;
            end
          end else if (!m_done[k]) begin
            if (m_edge == m_due[k]) begin
              m_done[k]    = 1;
              exp_ready[k] = 1'b1;
              exp_err[k]   = is_bad(m_addr[k]);
              if (is_bad(m_addr[k])) exp_din[k] = '0;
              else if (m_rw[k] == RW_WRITE) m_mem[key_of(k, m_addr[k])] = m_data[k];
              else exp_din[k] = m_mem[key_of(k, m_addr[k])];
            end
          end else if (!req[k]) begin
            m_busy[k] = 0; m_done[k] = 0;
            exp_ready[k] = 1'b0; exp_err[k] = 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(exp_ready[k]));
          check($sformatf("err[%0d]", k), 32'(er[k]), 32'(exp_err[k]));
          check($sformatf("din[%0d]", k), din[k], exp_din[k]);
        end
      end
    end
  end

  // One handshake. lat returns edges from acceptance to ready (-1 for a dropped-req access).
  task automatic access(input int k, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input bit viol, output int lat,
                        output logic [31:0] got_din, output logic got_err);
    @(negedge clk);
    rw = rd; addr = a; dout = d; req[k] = 1'b1;
    lat = 0;
    if (viol) begin
      @(negedge clk);
      req[k] = 1'b0; rw = 1'($urandom_range(0, 1)); addr = $urandom; dout = $urandom;
      repeat (ws_of(k) + 4) @(negedge clk);
      got_din = din[k]; got_err = er[k]; lat = -1;
      return;
    end
    forever begin
      @(posedge clk); #1;
      lat++;
      if (rdy[k]) break;
      // Inputs after acceptance must be ignored.
      rw = 1'($urandom_range(0, 1)); addr = $urandom; dout = $urandom;
      if (lat > 40) begin
        check("ready_timeout", 32'(rdy[k]), 32'd1);
        break;
      end
    end
    got_din = din[k]; got_err = er[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("ready_held", 32'(rdy[k]), 32'd1);
    end
    @(negedge clk);
    req[k] = 1'b0;
    lat = lat - 1;
  endtask

  logic [31:0] wq0 [$];
  logic [31:0] wq1 [$];

  initial begin
    int          lat;
    logic [31:0] gd;
    logic        ge;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; rw = 1'b1; addr = '0; dout = '0;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_din", din[0], 32'h0);
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_err", 32'(er[0]), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    rst_n = 1'b1;

    access(0, RW_WRITE, 32'h0000_0010, 32'h9abc_def0, 0, 0, lat, gd, ge);
    wq0.push_back(32'h0000_0010);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_err", 32'(ge), 32'd0);
    check("wr_din_unchanged", gd, 32'h0);

    access(0, RW_READ, 32'h0000_0010, 32'h0, 0, 0, lat, gd, ge);
    check("rd_data", gd, 32'h9abc_def0);
    check("rd_err", 32'(ge), 32'd0);
    repeat (3) @(negedge clk);
    check("rd_din_hold", din[0], 32'h9abc_def0);

    access(0, RW_READ, 32'h0000_0012, 32'h0, 0, 0, lat, gd, ge);
    check("misalign_err", 32'(ge), 32'd1);
    check("misalign_din", gd, 32'h0);
    access(0, RW_WRITE, 32'h0000_0400, 32'hdead_beef, 0, 0, lat, gd, ge);
    check("oor_err", 32'(ge), 32'd1);
    check("oor_din", gd, 32'h0);
    access(0, RW_READ, 32'h0000_0010, 32'h0, 0, 0, lat, gd, ge);
    check("reread_data", gd, 32'h9abc_def0);

    access(0, RW_READ, 32'h0000_0010, 32'h0, 5, 0, lat, gd, ge);
    @(posedge clk); #1;
    check("ready_fall", 32'(rdy[0]), 32'd0);

    access(0, RW_WRITE, 32'h0000_0020, 32'h0, 0, 0, lat, gd, ge);
    wq0.push_back(32'h0000_0020);
    @(negedge clk);
    rw = RW_WRITE; addr = 32'h0000_0020; dout = 32'h1234_5678; req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; req[0] = 1'b0;
    #2;
    check("abort_ready", 32'(rdy[0]), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(StIdle));
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_state_after", 32'(dut.state_q), 32'(StIdle));
    access(0, RW_READ, 32'h0000_0020, 32'h0, 0, 0, lat, gd, ge);
    check("abort_no_write", gd, 32'h0);

    access(1, RW_WRITE, 32'h0000_0040, 32'ha5a5_5a5a, 0, 0, lat, gd, ge);
    wq1.push_back(32'h0000_0040);
    check("ws0_wr_latency", 32'(lat), 32'd1);
    access(1, RW_READ, 32'h0000_0040, 32'h0, 0, 0, lat, gd, ge);
    check("ws0_rd_latency", 32'(lat), 32'd1);
    check("ws0_rd_data", gd, 32'ha5a5_5a5a);

    for (int t = 0; t < 80; t++) begin
      int          k;
      int unsigned sel;
      logic        rd;
      logic [31:0] a;
      bit          viol;
      k    = int'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      rd   = RW_WRITE;
      viol = ($urandom_range(0, 7) == 0);
      if (sel < 6) begin
        if (sel < 3 && k == 0 && wq0.size() > 0) begin
          a = wq0[$urandom_range(0, wq0.size() - 1)]; rd = RW_READ;
        end else if (sel < 3 && k == 1 && wq1.size() > 0) begin
          a = wq1[$urandom_range(0, wq1.size() - 1)]; rd = RW_READ;
        end else begin
          a = (sel == 5) ? 32'h0000_03fc : 32'($urandom_range(0, 15)) << 2;
          if (k == 0) wq0.push_back(a);
          else wq1.push_back(a);
        end
      end else begin
        rd = 1'($urandom_range(0, 1));
        if (sel == 6) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        else if (sel == 7) a = 32'h0000_0400 + (32'($urandom_range(0, 255)) << 2);
        else a = 32'hffff_fffc;
      end
      access(k, rd, a, $urandom, int'($urandom_range(0, 3)), viol, lat, gd, ge);
      if (!viol) check("rand_latency", 32'(lat), 32'(ws_of(k) + 1));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit memory words.
REQ-002 The parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0.
REQ-003 The parameter WAIT_STATES, default 2, range 0..15, SHALL set the number of extra access cycles.
REQ-004 The port clk SHALL be an input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit, the reset: asynchronous and active-low.
REQ-006 The port req SHALL be an input, 1 bit, the access request from the memory controller; it is held until ready.
REQ-007 The port RW SHALL be an input, 1 bit: 1 = read (LDR), 0 = write (STR).
REQ-008 The port AddressBus SHALL be an input, 32 bits, the byte address.
REQ-009 The port Dout SHALL be an input, 32 bits, the write data from the controller.
REQ-010 The port Din SHALL be an output, 32 bits, the read data to the controller.
REQ-011 The port ready SHALL be an output, 1 bit, access complete; it is held until req falls.
REQ-012 The port err SHALL be an output, 1 bit, access rejected; it is valid only while ready is high.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT and DONE, and SHALL encode them in 2 bits.
REQ-014 In IDLE with req=1 at edge N, the block SHALL latch RW, AddressBus and Dout, load cnt=WAIT_STATES, and go to WAIT.
REQ-015 In WAIT, the block SHALL decrement cnt when cnt!=0; when cnt==0 it SHALL perform the access and go to DONE. DONE is therefore entered at edge N+WAIT_STATES+1.
REQ-016 Changes on RW, AddressBus or Dout after the acceptance edge SHALL be ignored until the block returns to IDLE.
REQ-017 A read SHALL load Din with mem[(addr-BASE_ADDR)>>2] on the DONE-entry edge, and Din SHALL hold that value until the next completed read.
REQ-018 A write SHALL update mem[(addr-BASE_ADDR)>>2] with the latched Dout on the DONE-entry edge, and Din SHALL remain unchanged.
REQ-019 An access SHALL be an error if addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS. In that case memory SHALL be unchanged, Din SHALL be set to 0, and err SHALL be 1 in DONE.
REQ-020 ready and err SHALL be registered outputs, high only in DONE.
REQ-021 In DONE the block SHALL stay while req=1 and go to IDLE on the first edge with req=0 (4-phase handshake).
REQ-022 If req drops in WAIT (protocol violation), the access SHALL still complete and DONE SHALL last exactly one cycle.
REQ-023 A read of a word written by the immediately preceding access SHALL return the new data.
REQ-024 The address offset arithmetic SHALL be 32-bit unsigned, and the index SHALL be truncated to clog2(DEPTH_WORDS) bits only after the range check.

Reset
REQ-025 With rst_n=0 the block SHALL asynchronously set state=IDLE, cnt=0, Din=0, ready=0 and err=0.
REQ-026 Reset during WAIT SHALL abort the access, and a pending write SHALL NOT be performed.
REQ-027 Memory array contents SHALL NOT be reset and are undefined until written.
REQ-028 After rst_n rises, the first edge with req=1 SHALL be accepted normally.

Structure
REQ-029 The shared package mem_if_pkg SHALL hold: the state encoding, RW_READ=1'b1, RW_WRITE=1'b0, OP_LDR=4'b1101 and OP_STR=4'b1110.
REQ-030 Storage SHALL be a sub-module mem_array: single port, synchronous write, synchronous read, and no reset.
REQ-031 The top module SHALL contain only the FSM, the wait counter, the request latches and the address check.

Verification
REQ-032 The bench SHALL run this case: with WAIT_STATES=2, write 32'h9abcdef0 at 32'h0000_0010; ready SHALL rise exactly 3 edges after acceptance with err=0, and Din SHALL be unchanged.
REQ-033 The bench SHALL run this case: read 32'h0000_0010; Din SHALL be 32'h9abcdef0 when ready=1, and Din SHALL hold after req falls.
REQ-034 The bench SHALL run this case: access at 32'h0000_0012 (misaligned), then at 32'h0000_0400 (beyond 256 words); each SHALL give ready=1, err=1 and Din=0, and a re-read of 32'h0000_0010 SHALL still return 32'h9abcdef0.
REQ-035 The bench SHALL run this case: hold req high for 5 cycles in DONE; ready SHALL stay 1, and no second access SHALL occur until req has been low for one edge.
REQ-036 The bench SHALL run this case: pulse rst_n low during WAIT of a write of 32'h12345678 to 32'h0000_0020; ready SHALL stay 0, state SHALL be IDLE, and a later read of that address SHALL NOT return 32'h12345678 (pre-written with 32'h0).
REQ-037 The bench SHALL run this case: with WAIT_STATES=0, a read SHALL complete with ready high 1 edge after acceptance.
